// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_mul_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN
  } state_e;

  // Conditional two's-complement negate. Callers zero-extend the operand and
  // truncate the result, so this works for any width up to 64 bits.
  function automatic logic [63:0] abs_w(input logic [63:0] x, input logic neg);
    return neg ? (~x + 64'd1) : x;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add step: conditional add of the multiplicand, then a right shift
// of {carry,acc,mplier} with the carry entering the top.
module mul_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   acc,
  input  logic [W-1:0] mplier,
  input  logic [W-1:0] mcand,
  output logic [W:0]   acc_nx,
  output logic [W-1:0] mplier_nx
);

  logic [W:0] sum;

  always_comb begin
    sum       = mplier[0] ? (acc + (W+1)'(mcand)) : acc;
    acc_nx    = {1'b0, sum[W:1]};
    mplier_nx = {sum[0], mplier[W-1:1]};
  end

endmodule

// File: rtl/seq_mul_n.sv
// W-bit sequential multiplier, one partial product per clock, with a
// start/done handshake and optional two's-complement mode.
module seq_mul_n
  import seq_mul_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned SIGNED_EN = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam int unsigned PW = 2 * W;

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W:0]     acc_q, acc_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic           neg_q, neg_d;
  logic           ready_d, busy_d, done_d;
  logic [PW-1:0]  prod_d;

  logic           signed_eff;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     step_acc;
  logic [W-1:0]   step_mplier;
  logic [PW-1:0]  prod_mag, prod_fix;

  mul_step #(.W(W)) u_step (
    .acc       (acc_q),
    .mplier    (mplier_q),
    .mcand     (mcand_q),
    .acc_nx    (step_acc),
    .mplier_nx (step_mplier)
  );

  // Operand magnitudes at capture; sign is reapplied to the final product.
  always_comb begin
    signed_eff = (SIGNED_EN != 0) && signed_mode;
    a_mag      = W'(abs_w(64'(a), signed_eff & a[W-1]));
    b_mag      = W'(abs_w(64'(b), signed_eff & b[W-1]));
    prod_mag   = {step_acc[W-1:0], step_mplier};
    prod_fix   = PW'(abs_w(64'(prod_mag), neg_q));
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    prod_d   = prod;
    ready_d  = ready;
    busy_d   = busy;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          count_d  = '0;
          acc_d    = '0;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_eff & (a[W-1] ^ b[W-1]);
        end
      end
      S_RUN: begin
        acc_d    = step_acc;
        mplier_d = step_mplier;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(W - 1)) begin
          state_d = S_IDLE;
          count_d = '0;
          done_d  = 1'b1;
          prod_d  = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      prod     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      ready    <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
      prod     <= prod_d;
    end
  end

endmodule

// File: tb/tb_seq_mul_n.sv
// Bench for seq_mul_n: W=8 signed, W=8 with signed mode disabled, and W=16.
module tb_seq_mul_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]       start_v, sm_v;
  logic [2:0][15:0] a_v, b_v;
  logic             r0, r1, r2, bz0, bz1, bz2, d0, d1, d2;
  logic [15:0]      p0, p1;
  logic [31:0]      p2;
  logic [2:0]       ready_v, busy_v, done_v;
  logic [31:0]      prod_v [3];

  int checks = 0;
  int failures = 0;

  seq_mul_n #(.W(8), .SIGNED_EN(1)) dut8 (
    .clk(clk), .reset(reset), .start(start_v[0]), .signed_mode(sm_v[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .ready(r0), .busy(bz0), .done(d0), .prod(p0));

  seq_mul_n #(.W(8), .SIGNED_EN(0)) dut8u (
    .clk(clk), .reset(reset), .start(start_v[1]), .signed_mode(sm_v[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .ready(r1), .busy(bz1), .done(d1), .prod(p1));

  seq_mul_n #(.W(16), .SIGNED_EN(1)) dut16 (
    .clk(clk), .reset(reset), .start(start_v[2]), .signed_mode(sm_v[2]),
    .a(a_v[2]), .b(b_v[2]), .ready(r2), .busy(bz2), .done(d2), .prod(p2));

  always_comb begin
    ready_v   = {r2, r1, r0};
    busy_v    = {bz2, bz1, bz0};
    done_v    = {d2, d1, d0};
    prod_v[0] = {16'h0, p0};
    prod_v[1] = {16'h0, p1};
    prod_v[2] = p2;
  end

  function automatic int wid(input int k);
    return (k == 2) ? 16 : 8;
  endfunction

  // Reference: interpret operands per mode and multiply with integer arithmetic.
  function automatic logic [31:0] ref_mul(input int k, input logic [15:0] av, input logic [15:0] bv,
                                          input logic smv);
    int w = wid(k);
    longint x, y, p;
    x = longint'({48'h0, av});
    y = longint'({48'h0, bv});
    if (w == 8) begin
      x = x & 64'sd255;
      y = y & 64'sd255;
    end
    if (smv && k != 1) begin
      if (x >= (64'sd1 <<< (w - 1))) x = x - (64'sd1 <<< w);
      if (y >= (64'sd1 <<< (w - 1))) y = y - (64'sd1 <<< w);
    end
    p = x * y;
    return (w == 16) ? 32'(p) : {16'h0, 16'(p)};
  endfunction

  task automatic issue(input int k, input logic [15:0] av, input logic [15:0] bv, input logic smv);
    int n = 0;
    while (!ready_v[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_v[k]) begin
      checks++;
      failures++;
      $display("FAIL issue_ready_timeout k=%0d ready=%b want 1", k, ready_v[k]);
    end
    a_v[k] = av; b_v[k] = bv; sm_v[k] = smv; start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    a_v[k] = 16'($urandom); b_v[k] = 16'($urandom); sm_v[k] = 1'($urandom);
  endtask

  task automatic collect(input int k, input bit noise, output int lat, output int nd,
                         output logic rdy, output logic [31:0] p_at, output logic [31:0] p_end);
    lat = -1; nd = 0; rdy = 1'b0; p_at = '0;
    for (int c = 1; c <= wid(k) + 3; c++) begin
      if (noise && c >= 2 && c <= 6) begin
        start_v[k] = 1'b1; a_v[k] = 16'($urandom); b_v[k] = 16'($urandom);
      end else begin
        start_v[k] = 1'b0;
      end
      @(posedge clk); #1;
      if (done_v[k]) begin
        nd++;
        if (lat < 0) begin
          lat = c; rdy = ready_v[k]; p_at = prod_v[k];
        end
      end
    end
    start_v[k] = 1'b0;
    p_end = prod_v[k];
  endtask

  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv, input logic smv,
                        input bit noise, output int lat, output int nd, output logic rdy,
                        output logic [31:0] p_at, output logic [31:0] p_end);
    issue(k, av, bv, smv);
    collect(k, noise, lat, nd, rdy, p_at, p_end);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      checks++; if (ready_v[k] !== 1'b1) begin failures++; $display("FAIL reset_ready k=%0d got %b want 1", k, ready_v[k]); end
      checks++; if (busy_v[k] !== 1'b0) begin failures++; $display("FAIL reset_busy k=%0d got %b want 0", k, busy_v[k]); end
      checks++; if (done_v[k] !== 1'b0) begin failures++; $display("FAIL reset_done k=%0d got %b want 0", k, done_v[k]); end
      checks++; if (prod_v[k] !== 32'h0) begin failures++; $display("FAIL reset_prod k=%0d got %h want 0", k, prod_v[k]); end
    end
  endtask

  task automatic test_unsigned();
    logic [15:0] ta [3] = '{16'd13, 16'd255, 16'd255};
    logic [15:0] tb [3] = '{16'd11, 16'd255, 16'd255};
    int          tk [3] = '{0, 0, 1};
    logic [31:0] te [3] = '{32'h008F, 32'hFE01, 32'hFE01};
    int lat, nd; logic rdy; logic [31:0] pa, pe;
    for (int i = 0; i < 3; i++) begin
      run_op(tk[i], ta[i], tb[i], (tk[i] == 1), 1'b0, lat, nd, rdy, pa, pe);
      checks++;
      if (pa !== te[i] || pe !== te[i]) begin
        failures++; $display("FAIL unsigned_prod case=%0d got %h/%h want %h", i, pa, pe, te[i]);
      end
      checks++;
      if (lat !== 8 || nd !== 1 || rdy !== 1'b1) begin
        failures++; $display("FAIL unsigned_handshake case=%0d lat=%0d ndone=%0d ready=%b want 8 1 1", i, lat, nd, rdy);
      end
    end
  endtask

  task automatic test_signed();
    logic [15:0] ta [5] = '{16'hFD, 16'h80, 16'h80, 16'h00, 16'h7F};
    logic [15:0] tb [5] = '{16'h05, 16'h80, 16'h7F, 16'hFF, 16'hFF};
    logic [31:0] te [5] = '{32'hFFF1, 32'h4000, 32'hC080, 32'h0000, 32'hFF81};
    int lat, nd; logic rdy; logic [31:0] pa, pe;
    for (int i = 0; i < 5; i++) begin
      run_op(0, ta[i], tb[i], 1'b1, 1'b0, lat, nd, rdy, pa, pe);
      checks++;
      if (pa !== te[i] || pe !== te[i]) begin
        failures++; $display("FAIL signed_prod case=%0d got %h/%h want %h", i, pa, pe, te[i]);
      end
      checks++;
      if (lat !== 8 || nd !== 1 || rdy !== 1'b1) begin
        failures++; $display("FAIL signed_handshake case=%0d lat=%0d ndone=%0d ready=%b want 8 1 1", i, lat, nd, rdy);
      end
    end
  endtask

  task automatic test_busy_ignored();
    int lat, nd; logic rdy; logic [31:0] pa, pe;
    run_op(0, 16'd13, 16'd11, 1'b0, 1'b1, lat, nd, rdy, pa, pe);
    checks++;
    if (pa !== 32'h008F || pe !== 32'h008F) begin
      failures++; $display("FAIL busy_ignored_prod got %h/%h want 0000008f", pa, pe);
    end
    checks++;
    if (lat !== 8 || nd !== 1) begin
      failures++; $display("FAIL busy_ignored_handshake lat=%0d ndone=%0d want 8 1", lat, nd);
    end
  endtask

  task automatic test_back_to_back();
    int lat1 = -1, lat, nd; logic rdy; logic [31:0] p1v = '0, pa, pe;
    issue(0, 16'hFD, 16'h05, 1'b1);
    for (int c = 1; c <= 12 && lat1 < 0; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin
        lat1 = c; p1v = prod_v[0];
        start_v[0] = 1'b1; a_v[0] = 16'd200; b_v[0] = 16'd3; sm_v[0] = 1'b0;
      end
    end
    checks++;
    if (lat1 !== 8 || p1v !== 32'hFFF1) begin
      failures++; $display("FAIL b2b_first lat=%0d prod=%h want 8 fff1", lat1, p1v);
    end
    @(posedge clk); #1;
    start_v[0] = 1'b0; a_v[0] = 16'($urandom); b_v[0] = 16'($urandom);
    collect(0, 1'b0, lat, nd, rdy, pa, pe);
    checks++;
    if (lat !== 8 || nd !== 1 || pa !== 32'd600) begin
      failures++; $display("FAIL b2b_second lat=%0d ndone=%0d prod=%h want 8 1 258", lat, nd, pa);
    end
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    issue(0, 16'd200, 16'd100, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || prod_v[0] !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_state ready=%b busy=%b done=%b prod=%h want 1 0 0 0",
               ready_v[0], busy_v[0], done_v[0], prod_v[0]);
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) nd++;
    end
    checks++;
    if (nd !== 0 || prod_v[0] !== 32'h0) begin
      failures++; $display("FAIL reset_mid_no_done ndone=%0d prod=%h want 0 0", nd, prod_v[0]);
    end
  endtask

  task automatic test_w16();
    int lat, nd; logic rdy; logic [31:0] pa, pe;
    run_op(2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat, nd, rdy, pa, pe);
    checks++;
    if (pa !== 32'hFFFE0001 || pe !== 32'hFFFE0001) begin
      failures++; $display("FAIL w16_prod got %h/%h want fffe0001", pa, pe);
    end
    checks++;
    if (lat !== 16 || nd !== 1 || rdy !== 1'b1) begin
      failures++; $display("FAIL w16_handshake lat=%0d ndone=%0d ready=%b want 16 1 1", lat, nd, rdy);
    end
  endtask

  task automatic test_random();
    int lat, nd; logic rdy; logic [31:0] pa, pe, exp;
    logic [15:0] av, bv; logic smv; int k;
    for (int i = 0; i < 240; i++) begin
      k = (i < 200) ? 2 : (i % 2);
      av = 16'($urandom); bv = 16'($urandom); smv = 1'($urandom);
      if (k != 2) begin av = av & 16'h00FF; bv = bv & 16'h00FF; end
      exp = ref_mul(k, av, bv, smv);
      run_op(k, av, bv, smv, 1'b0, lat, nd, rdy, pa, pe);
      checks++;
      if (pa !== exp || lat !== wid(k) || nd !== 1) begin
        failures++;
        $display("FAIL random k=%0d a=%h b=%h s=%b prod=%h lat=%0d ndone=%0d want %h %0d 1",
                 k, av, bv, smv, pa, lat, nd, exp, wid(k));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start_v = '0; sm_v = '0; a_v = '0; b_v = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_unsigned();
    test_signed();
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid();
    test_w16();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
